// File: rtl/exec_pkg.sv
// exec_pkg: shared ALU opcodes, ARM condition codes and NZCV flag layout
package exec_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_e;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;
endpackage

// File: rtl/cond_check.sv
// cond_check: ARM condition-code evaluation against the current NZCV flags
module cond_check
  import exec_pkg::*;
(
  input  cond_e cond,
  input  nzcv_t f,
  output logic  pass
);
  always_comb begin
    pass = 1'b1;
    case (cond)
      C_EQ: pass = f.z;
      C_NE: pass = !f.z;
      C_CS: pass = f.c;
      C_CC: pass = !f.c;
      C_MI: pass = f.n;
      C_PL: pass = !f.n;
      C_VS: pass = f.v;
      C_VC: pass = !f.v;
      C_HI: pass = f.c && !f.z;
      C_LS: pass = !f.c || f.z;
      C_GE: pass = f.n == f.v;
      C_LT: pass = f.n != f.v;
      C_GT: pass = !f.z && (f.n == f.v);
      C_LE: pass = f.z || (f.n != f.v);
      default: pass = 1'b1;
    endcase
  end
endmodule

// File: rtl/exec_flags_stage.sv
// exec_flags_stage: condition check, NZCV update and 2-entry writeback FIFO
module exec_flags_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_zero,
  input  logic              op_a_msb,
  input  logic              op_b_msb,
  input  logic [3:0]        alu_op,
  input  logic [3:0]        cond,
  input  logic              set_flags,
  input  logic              wr_req,
  input  logic [3:0]        rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_rd,
  output logic              out_we,
  output logic [3:0]        flags
);
  logic [DATA_W-1:0] dat [DEPTH];
  logic [3:0]        rdq [DEPTH];
  logic [DEPTH-1:0]  weq;
  logic [1:0]        count;
  nzcv_t             f;
  logic              pass, push, pop, upd, wi, res_msb, v_add, v_sub;
  cond_check u_cond (.cond(cond_e'(cond)), .f(f), .pass(pass));
  assign in_ready  = count < 2'(DEPTH);
  assign out_valid = count != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign upd       = push && pass && set_flags;
  assign wi        = (count == 2'd1) && !pop;
  assign res_msb   = alu_result[DATA_W-1];
  assign v_add     = (op_a_msb == op_b_msb) && (res_msb != op_a_msb);
  assign v_sub     = (op_a_msb != op_b_msb) && (res_msb != op_a_msb);
  assign out_data  = dat[0];
  assign out_rd    = rdq[0];
  assign out_we    = out_valid && weq[0];
  assign flags     = f;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      f     <= '0;
      weq   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= '0;
        rdq[i] <= '0;
      end
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop) begin
        dat[0] <= dat[1];
        rdq[0] <= rdq[1];
        weq[0] <= weq[1];
      end
      if (push) begin
        dat[wi] <= alu_result;
        rdq[wi] <= rd;
        weq[wi] <= pass && wr_req;
      end
      if (upd)
        f <= '{n: res_msb, z: alu_zero,
               c: (alu_op == OP_ADD || alu_op == OP_SUB) ? alu_cout : f.c,
               v: alu_op == OP_ADD ? v_add : alu_op == OP_SUB ? v_sub : f.v};
    end
  end
endmodule

// File: tb/tb_exec_flags_stage.sv
// tb_exec_flags_stage: randomized scoreboard bench for exec_flags_stage
module tb_exec_flags_stage;
  localparam logic [3:0] ADD = 4'b0100, SUB = 4'b0010, ANDOP = 4'b0000, ORR = 4'b1100;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  logic clk = 0, rst_n = 1, in_valid = 0, alu_cout = 0, alu_zero = 0;
  logic op_a_msb = 0, op_b_msb = 0, set_flags = 0, wr_req = 0, out_ready = 0;
  logic in_ready, out_valid, out_we;
  logic [31:0] alu_result = 0, out_data;
  logic [3:0] alu_op = 0, cond = 0, rd = 0, out_rd, flags;
  typedef struct {logic [31:0] d; logic [3:0] r; logic w;} ent_t;
  ent_t exp_q[$];
  logic [3:0] mf = 0;
  int checks = 0, errors = 0;
  bit rr = 0;

  exec_flags_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .op_a_msb(op_a_msb), .op_b_msb(op_b_msb), .alu_op(alu_op), .cond(cond),
    .set_flags(set_flags), .wr_req(wr_req), .rd(rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
    .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] fl);
    bit n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return cy;
      4'd3: return !cy;
      4'd4: return n;
      4'd5: return !n;
      4'd6: return v;
      4'd7: return !v;
      4'd8: return cy && !z;
      4'd9: return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Reference: flags from signed/unsigned arithmetic on the true operands
  task automatic model_accept(input logic [3:0] op, input logic [31:0] a, b, res,
                              input logic [3:0] cnd, input bit s, wr, input logic [3:0] r);
    bit p;
    longint sa, sb, sr;
    p  = cond_ok(cnd, mf);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = (op == ADD) ? sa + sb : sa - sb;
    if (p && s) begin
      mf[3] = res[31];
      mf[2] = res == 0;
      if (op == ADD) begin
        mf[1] = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        mf[0] = sr > SMAX || sr < SMIN;
      end else if (op == SUB) begin
        mf[1] = a >= b;
        mf[0] = sr > SMAX || sr < SMIN;
      end
    end
    exp_q.push_back('{d: res, r: r, w: p && wr});
  endtask

  task automatic attempt(input logic [3:0] op, input logic [31:0] a, b, input logic [3:0] cnd,
                         input bit s, wr, input logic [3:0] r, input int tries, output bit ok);
    logic [31:0] res;
    logic [32:0] s33;
    res = op == ADD ? a + b : op == SUB ? a - b : op == ANDOP ? a & b : a | b;
    s33 = {1'b0, a} + {1'b0, b};
    alu_op = op; alu_result = res; alu_zero = res == 0;
    op_a_msb = a[31]; op_b_msb = b[31];
    alu_cout = op == ADD ? s33[32] : op == SUB ? (a >= b) : 1'($urandom);
    cond = cnd; set_flags = s; wr_req = wr; rd = r; in_valid = 1; ok = 0;
    for (int t = 0; t < tries && !ok; t++) begin
      @(negedge clk);
      chk("flags", flags, mf);
      if (in_ready) begin
        model_accept(op, a, b, res, cnd, s, wr, r);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, b, input logic [3:0] cnd,
                       input bit s, wr, input logic [3:0] r);
    bit ok;
    attempt(op, a, b, cnd, s, wr, r, 64, ok);
    chk("accept", ok, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial forever begin
    @(posedge clk); #1;
    if (rr) out_ready = $urandom_range(0, 3) != 0;
  end

  // Monitor: pops the scoreboard on every handshake seen before the edge
  initial begin
    logic [36:0] prev;
    bit stall;
    ent_t e;
    stall = 0; prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 0;
      else begin
        if (!out_valid) chk("we_idle", out_we, 0);
        else begin
          if (stall) chk("head_hold", {out_data, out_rd, out_we}, prev);
          if (out_ready) begin
            chk("q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("out", {out_data, out_rd, out_we}, {e.d, e.r, e.w});
            end
          end
        end
        stall = out_valid && !out_ready;
        prev  = {out_data, out_rd, out_we};
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at %0t", $time);
    $fatal;
  end

  initial begin
    bit ok;
    int acc, k;
    logic [3:0] op;
    logic [31:0] a, b;
    #1 rst_n = 0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_outs", {out_data, out_rd, out_we}, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("rst_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1;
    issue(ADD, 32'h7FFF_FFFF, 32'h1, 4'hE, 1, 1, 4'd3);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 32'h8000_0000);
    chk("lat_we", out_we, 1);
    chk("add_ovf_flags", flags, 4'b1001);
    issue(SUB, 32'd5, 32'd5, 4'hE, 1, 1, 4'd4);
    issue(ANDOP, 32'hFF, 32'h0F, 4'h0, 0, 1, 4'd5);
    chk("eq_flags", flags, 4'b0110);
    chk("eq_we", out_we, 1);
    chk("eq_rd", out_rd, 4'd5);
    issue(ADD, 32'd1, 32'd1, 4'h1, 1, 1, 4'd6);
    chk("ne_we", out_we, 0);
    chk("ne_rd", out_rd, 4'd6);
    chk("ne_flags", flags, 4'b0110);
    issue(SUB, 32'h8000_0000, 32'h1, 4'hE, 1, 0, 4'd0);
    chk("subv_flags", flags, 4'b0011);
    issue(ANDOP, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'hE, 1, 1, 4'd1);
    chk("and_flags", flags, 4'b0111);
    idle(3);
    out_ready = 0;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      attempt(ADD, 32'(i * 16), 32'h1, 4'hE, 0, 1, 4'(i + 8), 1, ok);
      acc += int'(ok);
    end
    chk("bp_acc", acc, 2);
    chk("bp_ready", in_ready, 0);
    chk("bp_head", out_rd, 4'd8);
    out_ready = 1;
    @(negedge clk); chk("bp_ready_reg", in_ready, 0);
    @(posedge clk); #1 chk("bp_ready_up", in_ready, 1);
    idle(3);
    chk("bp_drain", exp_q.size(), 0);
    rr = 1;
    repeat (400) begin
      k  = $urandom_range(0, 3);
      op = k == 0 ? ADD : k == 1 ? SUB : k == 2 ? ANDOP : ORR;
      a  = pick();
      b  = ($urandom_range(0, 4) == 0) ? a : pick();
      issue(op, a, b, 4'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rr = 0;
    out_ready = 1;
    idle(4);
    out_ready = 0;
    issue(ADD, 32'd10, 32'd20, 4'hE, 1, 1, 4'd2);
    issue(SUB, 32'd1, 32'd2, 4'hE, 1, 1, 4'd3);
    chk("full_ready", in_ready, 0);
    rst_n = 0;
    exp_q.delete();
    mf = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_flags", flags, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("mid_rst_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1;
    issue(ADD, 32'd2, 32'd3, 4'hE, 1, 1, 4'd1);
    chk("post_rst_flags", flags, 4'b0000);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    chk("final_drain", exp_q.size(), 0);
    chk("final_valid", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
